// File: rtl/delayed_res_sd_sim.sv
// delayed_res_sd_sim
// Two independent functions sharing one clock:
//   * Debounced delayed reset: btn_reset is synchronized, held-high cycles are
//     counted, and res_pulse fires once when the hold reaches HOLD_CYCLES.
//   * Single-port 2^ADDR_W x DATA_W memory, read-first, one-cycle read latency,
//     whose contents power up as mem[a] = a and survive reset.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (flops only, never memory contents)
//   btn_reset  raw asynchronous button level, active-high
//   res_pulse  registered one-cycle delayed-reset pulse
//   ena/wea    memory enable / write enable (write qualified by ena)
//   addra      memory address
//   dina       memory write data
//   douta      registered memory read data
module delayed_res_sd_sim #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_reset,
    output logic              res_pulse,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(HOLD_CYCLES - 1);

    // ------------------------------------------------------------------
    // Delayed reset pulse generator
    // ------------------------------------------------------------------
    logic             btn_meta;
    logic             btn_s;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             pulse_nxt;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_reset;
            btn_s    <= btn_meta;
        end
    end

    // Saturating hold counter; the pulse fires only on the HOLD-1 -> HOLD step,
    // so a sustained hold cannot re-trigger until btn_s drops and clears it.
    always_comb begin
        hold_cnt_nxt = '0;
        pulse_nxt    = 1'b0;
        if (btn_s) begin
            if (hold_cnt < HOLD_MAX) begin
                hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end else begin
                hold_cnt_nxt = hold_cnt;
            end
            pulse_nxt = (hold_cnt == HOLD_PRE);
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt  <= '0;
            res_pulse <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_nxt;
            res_pulse <= pulse_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Single-port read-first memory
    // ------------------------------------------------------------------
    // Each word is stored XOR-ed with its own address. The 2-state array powers
    // up all-zero, which therefore decodes to mem[a] = a without any load
    // sequence, and reset never touches it.
    bit   [DATA_W-1:0] mem_x [DEPTH];
    logic              wr_en;
    logic [DATA_W-1:0] addr_ext;

    assign wr_en    = reset & ena & wea;
    assign addr_ext = DATA_W'(addra);

    // Storage write; no reset so contents persist across reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_x[addra] <= dina ^ addr_ext;
        end
    end

    // Registered read; nonblocking semantics give pre-write (read-first) data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            douta <= '0;
        end else if (ena) begin
            douta <= mem_x[addra] ^ addr_ext;
        end
    end

endmodule

// File: tb/tb_delayed_res_sd_sim.sv
// Testbench for delayed_res_sd_sim: vector table for memory behaviour, hand
// sequences for the hold/pulse and reset corner cases, then randomized traffic
// against a history-based reference model.
module tb_delayed_res_sd_sim;

    localparam int unsigned HOLD  = 4;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 11;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          btn_reset = 1'b0;
    logic          ena       = 1'b0;
    logic          wea       = 1'b0;
    logic [AW-1:0] addra     = '0;
    logic [DW-1:0] dina      = '0;
    logic          res_pulse;
    logic [DW-1:0] douta;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    logic          exp_pulse;
    logic [DW-1:0] exp_dout;
    bit            hist[$];   // btn_reset samples taken at each edge since reset release

    delayed_res_sd_sim #(
        .HOLD_CYCLES(HOLD),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_reset(btn_reset),
        .res_pulse(res_pulse),
        .ena      (ena),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .douta    (douta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update for one rising edge. A pulse is due when the run of
    // consecutive high samples, ignoring the two still inside the
    // synchronizer, has just reached exactly HOLD.
    task automatic model_edge();
        int run;
        if (!reset) begin
            hist.delete();
            exp_dout  = '0;
            exp_pulse = 1'b0;
        end else begin
            if (ena) begin
                exp_dout = mem_m[addra];
                if (wea) mem_m[addra] = dina;
            end
            hist.push_back(btn_reset);
            run = 0;
            for (int i = hist.size() - 3; i >= 0; i--) begin
                if (!hist[i]) break;
                run++;
            end
            exp_pulse = (run == int'(HOLD));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_pulse"}, 32'(res_pulse), 32'(exp_pulse));
        chk({tag, "_dout"},  32'(douta),     32'(exp_dout));
    endtask

    task automatic drive(input logic b, input logic e, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        btn_reset = b;
        ena       = e;
        wea       = w;
        addra     = a;
        dina      = d;
    endtask

    // Asynchronous reset assertion between edges; model cleared to match.
    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_async_pulse"}, 32'(res_pulse), 32'd0);
        chk({tag, "_async_dout"},  32'(douta),     32'd0);
        hist.delete();
        exp_pulse = 1'b0;
        exp_dout  = '0;
    endtask

    typedef struct {
        logic          ena;
        logic          wea;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_dout;
        logic          exp_pulse;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int pulses;
        int seen;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = DW'(i);
        exp_pulse = 1'b0;
        exp_dout  = '0;

        vecs[0] = '{1'b1, 1'b0, 8'd5,   11'd0,     11'd5,     1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'd0,   11'd0,     11'd0,     1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'd3,   11'h7FF,   11'd3,     1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'd3,   11'd0,     11'h7FF,   1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'd7,   11'h123,   11'h7FF,   1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'd7,   11'd0,     11'd7,     1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'd10,  11'd0,     11'd10,    1'b0};
        vecs[7] = '{1'b0, 1'b0, 8'd0,   11'd0,     11'd10,    1'b0};
        vecs[8] = '{1'b1, 1'b1, 8'd255, 11'h055,   11'h0FF,   1'b0};
        vecs[9] = '{1'b1, 1'b0, 8'd255, 11'd0,     11'h055,   1'b0};

        // Reset state
        #2;
        chk("reset_pulse", 32'(res_pulse), 32'd0);
        chk("reset_dout",  32'(douta),     32'd0);
        cycle();
        cycle();
        reset = 1'b1;

        // Memory vector table
        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].ena, vecs[i].wea, vecs[i].addr, vecs[i].din);
            cycle();
            chk($sformatf("vec%0d_dout", i),  32'(douta),     32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_pulse", i), 32'(res_pulse), 32'(vecs[i].exp_pulse));
        end

        // Reset preserves memory; writes during reset ignored
        drive(1'b0, 1'b0, 1'b0, 8'd0, 11'd0);
        async_reset_check("memrst");
        drive(1'b0, 1'b1, 1'b1, 8'd9, 11'h3AA);
        cycle();
        chk("inreset_dout", 32'(douta), 32'd0);
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'd9, 11'd0);
        cycle();
        chk("postrst_addr9", 32'(douta), 32'd9);
        drive(1'b0, 1'b1, 1'b0, 8'd3, 11'd0);
        cycle();
        chk("postrst_addr3", 32'(douta), 32'h7FF);

        // Button held from before edge 1: single pulse after edge HOLD+2
        drive(1'b0, 1'b0, 1'b0, 8'd0, 11'd0);
        repeat (3) cycle();
        btn_reset = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            cycle();
            chk($sformatf("hold_edge%0d", e), 32'(res_pulse), 32'(e == int'(HOLD) + 2));
            chk_model("hold");
        end

        // Short glitch gives no pulse; a following 10-cycle hold gives one
        btn_reset = 1'b0;
        repeat (4) cycle();
        pulses = 0;
        btn_reset = 1'b1;
        repeat (3) begin cycle(); pulses += int'(res_pulse); chk_model("glitch"); end
        btn_reset = 1'b0;
        repeat (6) begin cycle(); pulses += int'(res_pulse); chk_model("glitch"); end
        chk("glitch_pulses", 32'(pulses), 32'd0);
        pulses = 0;
        btn_reset = 1'b1;
        repeat (10) begin cycle(); pulses += int'(res_pulse); chk_model("long"); end
        btn_reset = 1'b0;
        repeat (4) begin cycle(); pulses += int'(res_pulse); chk_model("long"); end
        chk("long_pulses", 32'(pulses), 32'd1);

        // Reset mid-hold at count 2 discards progress
        drive(1'b1, 1'b1, 1'b0, 8'd5, 11'd0);
        repeat (4) cycle();
        chk("midhold_dout", 32'(douta), 32'd5);
        async_reset_check("midhold");
        repeat (2) cycle();
        reset = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            cycle();
            chk($sformatf("rehold_edge%0d", e), 32'(res_pulse), 32'(e == int'(HOLD) + 2));
            chk_model("rehold");
        end

        // Reset while res_pulse is high drops it immediately
        drive(1'b0, 1'b0, 1'b0, 8'd0, 11'd0);
        repeat (3) cycle();
        btn_reset = 1'b1;
        seen = 0;
        for (int e = 0; e < 20 && seen == 0; e++) begin
            cycle();
            if (res_pulse) seen = 1;
        end
        chk("pulse_seen", 32'(seen), 32'd1);
        async_reset_check("inpulse");
        cycle();
        reset = 1'b1;
        btn_reset = 1'b0;
        cycle();
        chk_model("afterpulse");

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic b;
            b = btn_reset;
            if ($urandom_range(0, 7) == 0) b = ~b;
            drive(b, 1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
            if ($urandom_range(0, 4) == 0) addra = AW'($urandom);
            reset = ($urandom_range(0, 99) != 0);
            cycle();
            chk_model("rand");
        end
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
